// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl
// Latches raw interrupt requests into a pending register and presents the
// highest-priority enabled pending request to a single consumer. The consumer
// takes the request with irq_ack and releases the block with eoi.
//
// Parameters:
//   MASK_RST   - reset value of the mask register (1 = request line enabled)
//
// Ports:
//   clk        - single clock; all state changes on its rising edge
//   rst_n      - asynchronous, active-low reset
//   req_in     - raw request lines; bit 7 has the highest priority
//   mask_wr    - mask register write strobe
//   mask_in    - mask write data
//   irq_ack    - consumer accepts the presented request
//   eoi        - consumer signals end of service
//   irq_valid  - a request is being presented
//   irq_id     - encoded index of the presented request (0 when not valid)
//   in_service - an accepted request is being serviced
//   pending    - pending register contents
//
// Configuration macro:
//   IRQ_EDGE_CAPTURE_EN - defined: a pending bit sets only on a 0->1 edge of
//                         its request line. Undefined (default): a pending bit
//                         sets on every cycle its request line is high, so a
//                         request that is still held re-pends after ack.

module irq_pending_ctrl #(
  parameter logic [7:0] MASK_RST = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_in,
  input  logic       mask_wr,
  input  logic [7:0] mask_in,
  input  logic       irq_ack,
  input  logic       eoi,
  output logic       irq_valid,
  output logic [2:0] irq_id,
  output logic       in_service,
  output logic [7:0] pending
);

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    SERVICE
  } state_t;

  state_t     state;
  logic [7:0] mask;
  logic [7:0] set_vec;
  logic [7:0] clr_vec;
  logic [7:0] eligible;
  logic [2:0] top_idx;

`ifdef IRQ_EDGE_CAPTURE_EN
  // Registered copy of the request lines, used to detect rising edges.
  logic [7:0] req_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_prev <= 8'h00;
    end else begin
      req_prev <= req_in;
    end
  end

  assign set_vec = req_in & ~req_prev;
`else
  assign set_vec = req_in;
`endif

  // Only an ack taken while presenting clears the presented bit.
  assign clr_vec  = ((state == PRESENT) && irq_ack) ? (8'h01 << irq_id) : 8'h00;
  assign eligible = pending & mask;

  // Highest set bit wins: later iterations overwrite earlier ones.
  always_comb begin
    top_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (eligible[i]) begin
        top_idx = 3'(i);
      end
    end
  end

  // Clear is applied before set so a new request on the acked bit survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 8'h00;
      mask    <= MASK_RST;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;
      if (mask_wr) begin
        mask <= mask_in;
      end
    end
  end

  // Presentation FSM. irq_id is latched on entry to PRESENT and held until
  // ack, so neither new requests nor mask writes can change it mid-present.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      irq_valid  <= 1'b0;
      irq_id     <= 3'd0;
      in_service <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|eligible) begin
            state     <= PRESENT;
            irq_valid <= 1'b1;
            irq_id    <= top_idx;
          end
        end
        PRESENT: begin
          if (irq_ack) begin
            state      <= SERVICE;
            irq_valid  <= 1'b0;
            irq_id     <= 3'd0;
            in_service <= 1'b1;
          end
        end
        SERVICE: begin
          if (eoi) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          irq_valid  <= 1'b0;
          irq_id     <= 3'd0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule
